// File: rtl/video_crop_core.sv
// -----------------------------------------------------------------------------
// video_crop_core
//
// Self-contained AXI4-Stream colour-bar video source with an output crop.
// An internal generator walks a SRC_W x SRC_H beat raster (two pixels per
// beat). Only the hsize x vsize window anchored at (0,0) is emitted, back to
// back, with no gaps where cropped beats would have been.
//
// Ports
//   aclk_50MHz  in   1   clock, rising edge
//   aresetn_0   in   1   asynchronous active-low reset
//   ap_start    in   1   run enable, sampled at frame boundaries
//   hsize       in   32  crop width in beats (0 or > SRC_W means SRC_W)
//   vsize       in   32  crop height in lines (0 or > SRC_H means SRC_H)
//   tdata       out  64  {4'b0, pixel1, pixel0}, pixel = {R, B, G}
//   tvalid      out  1   beat valid
//   tready      in   1   downstream ready
//   tuser       out  1   start of frame (first beat of a frame only)
//   tlast       out  1   end of line
// -----------------------------------------------------------------------------
module video_crop_core #(
    parameter int SRC_W = 480,
    parameter int SRC_H = 640,
    parameter int CW    = 10
) (
    input  logic        aclk_50MHz,
    input  logic        aresetn_0,
    input  logic        ap_start,
    input  logic [31:0] hsize,
    input  logic [31:0] vsize,
    output logic [63:0] tdata,
    output logic        tvalid,
    input  logic        tready,
    output logic        tuser,
    output logic        tlast
);

    localparam int XW = $clog2(SRC_W + 1);
    localparam int YW = $clog2(SRC_H + 1);
    // The bar accumulator never exceeds SRC_W + 7 before it is folded back.
    localparam int AW = $clog2(SRC_W + 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state_q;
    logic [XW-1:0]   win_w_q;
    logic [YW-1:0]   win_h_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [AW-1:0]   acc_q;
    logic [2:0]      bar_q;
    logic            tvalid_q;
    logic            tuser_q;
    logic            tlast_q;
    logic [63:0]     tdata_q;

    logic [XW-1:0]   win_w_d;
    logic [YW-1:0]   win_h_d;
    logic            load_s;
    logic            line_end_s;
    logic            frame_end_s;
    logic [AW-1:0]   acc_step_s;
    logic            acc_wrap_s;
    logic [3*CW-1:0] pix_s;
    logic [63:0]     tdata_d;

    // Colour of one bar as a {R, B, G} pixel with full-scale or zero components.
    function automatic logic [3*CW-1:0] bar_pixel(input logic [2:0] bar);
        logic [2:0] rgb;
        case (bar)
            3'd0:    rgb = 3'b111; // white
            3'd1:    rgb = 3'b110; // yellow
            3'd2:    rgb = 3'b011; // cyan
            3'd3:    rgb = 3'b010; // green
            3'd4:    rgb = 3'b101; // magenta
            3'd5:    rgb = 3'b100; // red
            3'd6:    rgb = 3'b001; // blue
            3'd7:    rgb = 3'b000; // black
            default: rgb = 3'b000;
        endcase
        return {{CW{rgb[2]}}, {CW{rgb[0]}}, {CW{rgb[1]}}};
    endfunction

    // Window to latch at the next frame start, with out-of-range sizes clamped.
    always_comb begin
        if ((hsize == 32'd0) || (hsize > 32'(SRC_W))) begin
            win_w_d = XW'(SRC_W);
        end else begin
            win_w_d = hsize[XW-1:0];
        end
        if ((vsize == 32'd0) || (vsize > 32'(SRC_H))) begin
            win_h_d = YW'(SRC_H);
        end else begin
            win_h_d = vsize[YW-1:0];
        end
    end

    // Raster position decode, bar accumulator step and next beat payload.
    always_comb begin
        // A new beat is generated whenever the output register is empty or
        // is being drained this cycle, which keeps the stream gap-free.
        load_s      = (state_q == ST_RUN) && (!tvalid_q || tready);
        line_end_s  = (x_q == (win_w_q - XW'(1)));
        frame_end_s = line_end_s && (y_q == (win_h_q - YW'(1)));
        acc_step_s  = acc_q + AW'(8);
        acc_wrap_s  = (acc_step_s >= AW'(SRC_W));
        pix_s       = bar_pixel(bar_q);
        tdata_d     = 64'd0;
        tdata_d[6*CW-1:0] = {pix_s, pix_s};
    end

    // Control FSM, raster counters and registered AXI4-Stream outputs.
    always_ff @(posedge aclk_50MHz or negedge aresetn_0) begin
        if (!aresetn_0) begin
            state_q  <= ST_IDLE;
            win_w_q  <= XW'(SRC_W);
            win_h_q  <= YW'(SRC_H);
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            bar_q    <= 3'd0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= 64'd0;
        end else begin
            // Drain: an accepted beat empties the output register unless a
            // fresh beat is loaded below in the same cycle.
            if (tvalid_q && tready) begin
                tvalid_q <= 1'b0;
                tuser_q  <= 1'b0;
                tlast_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (ap_start) begin
                        state_q <= ST_START;
                        win_w_q <= win_w_d;
                        win_h_q <= win_h_d;
                        x_q     <= '0;
                        y_q     <= '0;
                        acc_q   <= '0;
                        bar_q   <= 3'd0;
                    end
                end

                // One settling cycle so the first beat lands two clocks
                // after ap_start is sampled.
                ST_START: begin
                    state_q <= ST_RUN;
                end

                ST_RUN: begin
                    if (load_s) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= tdata_d;
                        tuser_q  <= (x_q == '0) && (y_q == '0);
                        tlast_q  <= line_end_s;
                        if (line_end_s) begin
                            x_q   <= '0;
                            acc_q <= '0;
                            bar_q <= 3'd0;
                            if (frame_end_s) begin
                                y_q <= '0;
                                // Frame boundary: either relatch the window
                                // and keep streaming, or stop.
                                if (ap_start) begin
                                    win_w_q <= win_w_d;
                                    win_h_q <= win_h_d;
                                end else begin
                                    state_q <= ST_IDLE;
                                end
                            end else begin
                                y_q <= y_q + YW'(1);
                            end
                        end else begin
                            x_q <= x_q + XW'(1);
                            // bar = floor(x*8/SRC_W) tracked incrementally.
                            if (acc_wrap_s) begin
                                acc_q <= acc_step_s - AW'(SRC_W);
                                bar_q <= bar_q + 3'd1;
                            end else begin
                                acc_q <= acc_step_s;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tdata  = tdata_q;
    assign tvalid = tvalid_q;
    assign tuser  = tuser_q;
    assign tlast  = tlast_q;

endmodule

// File: tb/tb_video_crop_core.sv
// -----------------------------------------------------------------------------
// tb_video_crop_core
//
// Scoreboard bench: each frame the stimulus requests is expanded by a
// behavioural model into its expected beats and queued; an independent
// monitor pops and compares every accepted beat and checks stall stability.
// The source height is reduced so full-frame scenarios stay short.
// -----------------------------------------------------------------------------
module tb_video_crop_core;

    localparam int SRC_W = 480;
    localparam int SRC_H = 24;
    localparam int CW    = 10;

    logic        aclk_50MHz = 1'b0;
    logic        aresetn_0  = 1'b0;
    logic        ap_start   = 1'b0;
    logic [31:0] hsize      = 32'd0;
    logic [31:0] vsize      = 32'd0;
    logic        tready     = 1'b1;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tuser;
    logic        tlast;

    int          checks     = 0;
    int          errors     = 0;
    int          rx_count   = 0;
    longint      cyc        = 0;
    longint      first_cyc  = 0;
    longint      last_cyc   = 0;
    bit          rand_ready = 1'b0;
    logic [65:0] exp_q[$];

    video_crop_core #(.SRC_W(SRC_W), .SRC_H(SRC_H), .CW(CW)) dut (
        .aclk_50MHz (aclk_50MHz),
        .aresetn_0  (aresetn_0),
        .ap_start   (ap_start),
        .hsize      (hsize),
        .vsize      (vsize),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tready     (tready),
        .tuser      (tuser),
        .tlast      (tlast)
    );

    // 50 MHz clock.
    always #10 aclk_50MHz = ~aclk_50MHz;

    // Downstream ready: constant high or ~50 % random, changed after each edge.
    always @(posedge aclk_50MHz) begin
        #1;
        tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Expected {tuser, tlast, tdata} of beat (x, y) in a frame of width w.
    function automatic logic [65:0] model_beat(input int x, input int y, input int w);
        int          bar;
        bit          r, g, b;
        logic [29:0] px;
        logic [63:0] d;
        bar = (x * 8) / SRC_W;
        // white, yellow, cyan, green, magenta, red, blue, black
        r  = (bar == 0) || (bar == 1) || (bar == 4) || (bar == 5);
        g  = (bar < 4);
        b  = (bar % 2) == 0;
        px = {{CW{r}}, {CW{b}}, {CW{g}}};
        d  = {4'b0000, px, px};
        return {((x == 0) && (y == 0)), (x == w - 1), d};
    endfunction

    function automatic int clamp(input int v, input int lim);
        return ((v <= 0) || (v > lim)) ? lim : v;
    endfunction

    task automatic push_frame(input int hs, input int vs, output int n);
        int w, h;
        w = clamp(hs, SRC_W);
        h = clamp(vs, SRC_H);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                exp_q.push_back(model_beat(x, y, w));
            end
        end
        n = w * h;
    endtask

    task automatic check1(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_rx(input int n, input int limit);
        int c;
        c = 0;
        while ((rx_count < n) && (c < limit)) begin
            @(posedge aclk_50MHz);
            c++;
        end
        check1("rx_timeout", 64'(rx_count >= n), 64'd1);
    endtask

    // Monitor: scoreboard compare on every transfer, stability on every stall.
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [65:0] prev_b = '0;
    always @(negedge aclk_50MHz) begin
        logic [65:0] got;
        logic [65:0] want;
        got = {tuser, tlast, tdata};
        if (!aresetn_0) begin
            prev_v = 1'b0;
        end else begin
            cyc++;
            if (prev_v && !prev_r) begin
                checks++;
                if (!tvalid || (got !== prev_b)) begin
                    errors++;
                    $display("FAIL stall_hold got=%0b/%h want=1/%h", tvalid, got, prev_b);
                end
            end
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat got=%h want=none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL beat%0d got=%h want=%h", rx_count, got, want);
                    end
                end
                if (rx_count == 0) first_cyc = cyc;
                last_cyc = cyc;
                rx_count++;
            end
            prev_v = tvalid;
            prev_r = tready;
            prev_b = got;
        end
    end

    // Stimulus.
    initial begin
        int base, n0, n1, n2, n3, n4, n5, n6;
        repeat (3) @(posedge aclk_50MHz);
        #1;
        check1("rst_tvalid", 64'(tvalid), 64'd0);
        check1("rst_tuser",  64'(tuser),  64'd0);
        check1("rst_tlast",  64'(tlast),  64'd0);
        check1("rst_tdata",  tdata,       64'd0);
        aresetn_0 = 1'b1;

        // Full-width frame, checking start latency.
        @(posedge aclk_50MHz);
        #1;
        hsize = 32'd480; vsize = 32'd24; ap_start = 1'b1;
        base = 0;
        push_frame(480, 24, n0);
        @(posedge aclk_50MHz);
        @(negedge aclk_50MHz);
        check1("lat_c1", 64'(tvalid), 64'd0);
        @(posedge aclk_50MHz);
        @(negedge aclk_50MHz);
        check1("lat_c2", 64'(tvalid), 64'd0);
        @(posedge aclk_50MHz);
        @(negedge aclk_50MHz);
        check1("lat_valid", 64'(tvalid), 64'd1);
        check1("lat_sof",   64'(tuser),  64'd1);

        // Cropped 100x5 frame.
        wait_rx(base + n0 / 2, 40000);
        hsize = 32'd100; vsize = 32'd5;
        base += n0;
        push_frame(100, 5, n1);

        // Clamped sizes.
        wait_rx(base + n1 / 2, 40000);
        hsize = 32'd0; vsize = 32'd9999;
        base += n1;
        push_frame(0, 9999, n2);
        wait_rx(base + 1, 40000);
        check1("no_gap", 64'(last_cyc - first_cyc), 64'(n0 + n1));

        // Random backpressure, then a mid-frame width change.
        wait_rx(base + n2 / 2, 40000);
        rand_ready = 1'b1;
        hsize = 32'd37; vsize = 32'd7;
        base += n2;
        push_frame(37, 7, n3);
        wait_rx(base + n3 / 2, 40000);
        hsize = 32'd200; vsize = 32'd3;
        base += n3;
        push_frame(200, 3, n4);

        // Drop ap_start mid-frame: the frame completes and the stream stops.
        wait_rx(base + n4 / 2, 40000);
        ap_start = 1'b0;
        base += n4;
        wait_rx(base, 40000);
        repeat (40) begin
            @(negedge aclk_50MHz);
            check1("idle_tvalid", 64'(tvalid), 64'd0);
        end

        // Reset in the middle of a line.
        rand_ready = 1'b0;
        hsize = 32'd50; vsize = 32'd4; ap_start = 1'b1;
        push_frame(50, 4, n5);
        wait_rx(base + 75, 40000);
        @(posedge aclk_50MHz);
        #2;
        aresetn_0 = 1'b0;
        #1;
        check1("mrst_tvalid", 64'(tvalid), 64'd0);
        check1("mrst_tuser",  64'(tuser),  64'd0);
        check1("mrst_tlast",  64'(tlast),  64'd0);
        check1("mrst_tdata",  tdata,       64'd0);
        exp_q.delete();
        base = rx_count;
        hsize = 32'd8; vsize = 32'd2;
        push_frame(8, 2, n6);
        repeat (3) @(posedge aclk_50MHz);
        #1;
        aresetn_0 = 1'b1;
        wait_rx(base + n6 / 2, 2000);
        ap_start = 1'b0;
        base += n6;
        wait_rx(base, 2000);
        repeat (10) begin
            @(negedge aclk_50MHz);
            check1("end_idle", 64'(tvalid), 64'd0);
        end
        check1("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time bound.
    initial begin
        #1900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
